// File: rtl/branch_pkg.sv
// Shared types and sizing helpers for the branch resolver slice.
package branch_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_PRED = 1'b1
  } resolver_state_e;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CW    = 16;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/outcome_fifo.sv
// 1-bit in-order FIFO of predicted directions; clear overrides push/pop.
module outcome_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = occ_w(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign full      = (occ_q == OW'(DEPTH));
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Requests predictions for fetched branches, tracks them in order and
// reports resolved outcomes/mispredicts back to the predictor.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CW    = DEF_CW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   ex_valid,
  input  logic                   ex_taken,
  output logic                   request,
  input  logic                   prediction,
  output logic                   result,
  output logic                   taken,
  output logic                   mispredict,
  output logic                   underflow_err,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CW-1:0]          branch_count,
  output logic [CW-1:0]          mispredict_count
);

  resolver_state_e state_q, state_d;
  logic pred_valid_q, pred_valid_d;
  logic pred_taken_q, pred_taken_d;
  logic result_q, result_d;
  logic taken_q, taken_d;
  logic mispredict_q, mispredict_d;
  logic underflow_q, underflow_d;
  logic [CW-1:0] branch_count_q, branch_count_d;
  logic [CW-1:0] mispredict_count_q, mispredict_count_d;

  logic fifo_head, fifo_full, fifo_empty;
  logic push, pop, flush;

  outcome_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (prediction),
    .pop       (pop),
    .clear     (flush),
    .head      (fifo_head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    fetch_ready        = 1'b0;
    request            = 1'b0;
    state_d            = state_q;
    pop                = ex_valid && !fifo_empty;
    flush              = pop && (fifo_head != ex_taken);
    push               = 1'b0;
    pred_valid_d       = 1'b0;
    pred_taken_d       = 1'b0;
    result_d           = pop;
    taken_d            = pop && ex_taken;
    mispredict_d       = flush;
    underflow_d        = underflow_q || (ex_valid && fifo_empty);
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    unique case (state_q)
      IDLE: begin
        fetch_ready = !fifo_full;
        request     = fetch_valid && fetch_ready;
        // A fetch accepted alongside a flush still requests, but its answer is dropped.
        if (request && !flush) begin
          state_d = WAIT_PRED;
        end
      end
      WAIT_PRED: begin
        push         = !flush;
        pred_valid_d = push;
        pred_taken_d = push && prediction;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      branch_count_d = branch_count_q + CW'(1);
    end
    if (flush) begin
      mispredict_count_d = mispredict_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      result_q           <= 1'b0;
      taken_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      underflow_q        <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      result_q           <= result_d;
      taken_q            <= taken_d;
      mispredict_q       <= mispredict_d;
      underflow_q        <= underflow_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign result           = result_q;
  assign taken            = taken_q;
  assign mispredict       = mispredict_q;
  assign underflow_err    = underflow_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed vector bench for branch_resolver (DEPTH=4, 4-bit counters to reach wrap).
module tb_branch_resolver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_valid, fetch_ready;
  logic       pred_valid, pred_taken;
  logic       ex_valid, ex_taken;
  logic       request, prediction;
  logic       result, taken, mispredict, underflow_err;
  logic [2:0] occupancy;
  logic [3:0] branch_count, mispredict_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  branch_resolver #(.DEPTH(4), .CW(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_taken         (ex_taken),
    .request          (request),
    .prediction       (prediction),
    .result           (result),
    .taken            (taken),
    .mispredict       (mispredict),
    .underflow_err    (underflow_err),
    .occupancy        (occupancy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fv, pr, ev, et;
    logic       rdy, req;
    logic       pv, pt, res, tk, mis;
    logic [2:0] occ;
    logic       uf;
    logic [3:0] bc, mc;
  } vec_t;

  localparam int NV = 34;
  vec_t tv[NV];

  function automatic vec_t v(input logic fv, pr, ev, et, rdy, req,
                             input logic pv, pt, res, tk, mis,
                             input logic [2:0] occ, input logic uf,
                             input logic [3:0] bc, mc);
    vec_t r;
    r.fv = fv; r.pr = pr; r.ev = ev; r.et = et;
    r.rdy = rdy; r.req = req;
    r.pv = pv; r.pt = pt; r.res = res; r.tk = tk; r.mis = mis;
    r.occ = occ; r.uf = uf; r.bc = bc; r.mc = mc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, pr, ev, et);
    fetch_valid = fv;
    prediction  = pr;
    ex_valid    = ev;
    ex_taken    = et;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         fv pr ev et rdy req pv pt res tk mis occ uf bc mc
    tv[0]  = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0);
    tv[1]  = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  1, 0, 0, 0);
    tv[2]  = v(0, 0, 1, 1, 1, 0,  0, 0, 1, 1, 0,  0, 0, 1, 0);
    tv[3]  = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 1, 0);
    tv[4]  = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  1, 0, 1, 0);
    tv[5]  = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  1, 0, 1, 0);
    tv[6]  = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  2, 0, 1, 0);
    tv[7]  = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  2, 0, 1, 0);
    tv[8]  = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  3, 0, 1, 0);
    tv[9]  = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  3, 0, 1, 0);
    tv[10] = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  4, 0, 1, 0);
    tv[11] = v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  4, 0, 1, 0);
    tv[12] = v(0, 0, 1, 1, 0, 0,  0, 0, 1, 1, 0,  3, 0, 2, 0);
    tv[13] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  3, 0, 2, 0);
    tv[14] = v(0, 1, 1, 1, 0, 0,  1, 1, 1, 1, 0,  3, 0, 3, 0);
    tv[15] = v(0, 0, 1, 1, 1, 0,  0, 0, 1, 1, 0,  2, 0, 4, 0);
    tv[16] = v(0, 0, 1, 1, 1, 0,  0, 0, 1, 1, 0,  1, 0, 5, 0);
    tv[17] = v(0, 0, 1, 1, 1, 0,  0, 0, 1, 1, 0,  0, 0, 6, 0);
    tv[18] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 6, 0);
    tv[19] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 6, 0);
    tv[20] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  1, 0, 6, 0);
    tv[21] = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  2, 0, 6, 0);
    tv[22] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  2, 0, 6, 0);
    tv[23] = v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  3, 0, 6, 0);
    tv[24] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  3, 0, 6, 0);
    tv[25] = v(0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 1,  0, 0, 7, 1);
    tv[26] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 7, 1);
    tv[27] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 7, 1);
    tv[28] = v(1, 0, 1, 1, 1, 1,  0, 0, 1, 1, 1,  0, 0, 8, 2);
    tv[29] = v(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 8, 2);
    tv[30] = v(0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0, 1, 8, 2);
    tv[31] = v(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 1, 8, 2);
    tv[32] = v(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0,  1, 1, 8, 2);
    tv[33] = v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 8, 2);

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset fetch_ready", 32'(fetch_ready), 32'd1);
    chk("reset request", 32'(request), 32'd0);
    chk("reset pred_valid", 32'(pred_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset mispredict", 32'(mispredict), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset branch_count", 32'(branch_count), 32'd0);
    chk("reset mispredict_count", 32'(mispredict_count), 32'd0);
    chk("reset underflow_err", 32'(underflow_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].fv, tv[i].pr, tv[i].ev, tv[i].et);
      #1;
      chk($sformatf("v%0d fetch_ready", i), 32'(fetch_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d request", i), 32'(request), 32'(tv[i].req));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pred_valid", i), 32'(pred_valid), 32'(tv[i].pv));
      if (tv[i].pv)
        chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(tv[i].pt));
      chk($sformatf("v%0d result", i), 32'(result), 32'(tv[i].res));
      if (tv[i].res)
        chk($sformatf("v%0d taken", i), 32'(taken), 32'(tv[i].tk));
      chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(tv[i].mis));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tv[i].occ));
      chk($sformatf("v%0d underflow_err", i), 32'(underflow_err), 32'(tv[i].uf));
      chk($sformatf("v%0d branch_count", i), 32'(branch_count), 32'(tv[i].bc));
      chk($sformatf("v%0d mispredict_count", i), 32'(mispredict_count), 32'(tv[i].mc));
    end

    // Eight more matching resolves, each paired with a push: 8 + 8 wraps a 4-bit count.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1, 1, 1);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d occupancy", i), 32'(occupancy), 32'd1);
      chk($sformatf("wrap%0d result", i), 32'(result), 32'd1);
    end
    chk("wrap branch_count", 32'(branch_count), 32'd0);
    chk("wrap mispredict_count", 32'(mispredict_count), 32'd2);

    // Reset asserted while waiting on a prediction.
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst fetch_ready", 32'(fetch_ready), 32'd1);
    chk("midrst request", 32'(request), 32'd0);
    chk("midrst occupancy", 32'(occupancy), 32'd0);
    chk("midrst underflow_err", 32'(underflow_err), 32'd0);
    chk("midrst pred_valid", 32'(pred_valid), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst branch_count", 32'(branch_count), 32'd0);
    chk("midrst mispredict_count", 32'(mispredict_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("postrst pred_valid", 32'(pred_valid), 32'd0);
    chk("postrst occupancy", 32'(occupancy), 32'd0);
    chk("postrst fetch_ready", 32'(fetch_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
